// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped, read-only instruction cache controller.
//   2**IDX_W lines of 4 words. A hit returns its word combinationally with no
//   stall. A miss stalls the fetch stage, requests the line from memory,
//   captures the data when mem_ready is high, writes the line, and then
//   re-looks up the same PC.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   proc_addr       fetch PC (byte address; bits [1:0] ignored)
//   proc_rdata      instruction word (0 / NOP while stalled)
//   proc_stall      hold the fetch stage
//   inv             one-cycle pulse that invalidates every line
//   mem_read        line-fill request, high only in MISS
//   mem_addr        line address PC[31:4] of the outstanding miss
//   mem_rdata       fill data, word0 in [31:0]
//   mem_ready       fill data valid; only looked at in MISS
//   miss_cnt        saturating count of IDLE->MISS transitions
module icache_ctrl #(
  parameter int IDX_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  proc_addr,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  input  logic         inv,
  output logic         mem_read,
  output logic [27:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [15:0]  miss_cnt
);

  localparam int NLINES = 1 << IDX_W;
  localparam int TAG_W  = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

  state_t state, nxt;

  logic [NLINES-1:0]             valid;
  logic [NLINES-1:0][TAG_W-1:0]  tag_arr;
  logic [NLINES-1:0][127:0]      data_arr;
  logic [127:0]                  line_buf;

  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic [1:0]       woff;
  logic             hit;

  assign idx  = proc_addr[IDX_W+3:4];
  assign tag  = proc_addr[31:IDX_W+4];
  assign woff = proc_addr[3:2];
  assign hit  = valid[idx] && (tag_arr[idx] == tag);

  // The miss register doubles as mem_addr, so the fill always targets the
  // PC that missed even if proc_addr moves while stalled.
  assign fill_idx = mem_addr[IDX_W-1:0];
  assign fill_tag = mem_addr[27:IDX_W];

  logic unused_ok;
  assign unused_ok = &{1'b0, proc_addr[1:0]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!hit)     nxt = MISS;
      MISS:    if (mem_ready) nxt = FILL;
      FILL:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs. mem_read is decoded from state so reset drops it at once.
  always_comb begin
    proc_stall = 1'b1;
    proc_rdata = 32'h0;
    mem_read   = 1'b0;
    case (state)
      IDLE: begin
        proc_stall = !hit;
        if (hit) proc_rdata = data_arr[idx][{woff, 5'b0} +: 32];
      end
      MISS:    mem_read = 1'b1;
      default: ;
    endcase
  end

  // Control datapath with reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= '0;
      mem_addr <= '0;
      miss_cnt <= '0;
      line_buf <= '0;
    end else begin
      if (state == IDLE && !hit) begin
        mem_addr <= proc_addr[31:4];
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
      if (state == MISS && mem_ready) line_buf <= mem_rdata;
      // inv wins over a fill landing on the same edge
      if (inv)                valid           <= '0;
      else if (state == FILL) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= line_buf;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  proc_addr;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         inv;
  logic         mem_read;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [15:0]  miss_cnt;

  int checks = 0;
  int failures = 0;

  icache_ctrl #(.IDX_W(3)) dut (
    .clk(clk), .rst(rst), .proc_addr(proc_addr), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .inv(inv), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive a fetch of a missing PC and serve the fill with mem_ready on the
  // lat-th cycle of mem_read. Returns the number of stalled cycles and the
  // line address seen on mem_addr; ends in the hit cycle.
  task automatic fetch_miss(input logic [31:0] a, input logic [127:0] d, input int lat,
                            output int stalls, output logic [27:0] maddr);
    int mr;
    mr = 0;
    stalls = 0;
    maddr = '0;
    proc_addr = a;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!proc_stall) break;
      stalls++;
      if (mem_read) begin
        mr++;
        maddr = mem_addr;
        mem_rdata = d;
        mem_ready = (mr == lat);
      end else begin
        mem_ready = 1'b0;
      end
      @(posedge clk);
    end
    mem_ready = 1'b0;
  endtask

  logic [127:0] d1, d2, d3, d4, d5, d6;
  int st;
  logic [27:0] ma;

  initial begin
    d1 = {32'h0C0DE003, 32'h0B0B0002, 32'h0A0A0001, 32'h20080005};
    d2 = {32'h33333333, 32'h22222222, 32'h11111111, 32'hC0C0C0C0};
    d3 = {32'h0, 32'h0, 32'h0, 32'h10010010};
    d4 = {32'h0, 32'h0, 32'h0, 32'h30030030};
    d5 = {32'h0, 32'h0, 32'h0, 32'h50050050};
    d6 = {32'h0, 32'h0, 32'h0, 32'h60060060};

    rst = 1'b0; inv = 1'b0; mem_ready = 1'b0; mem_rdata = '0; proc_addr = 32'h40;
    #1;
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_addr", {4'b0, mem_addr}, 32'd0);
    chk("rst_miss_cnt", {16'b0, miss_cnt}, 32'd0);
    step; step;
    rst = 1'b1;
    #1;
    chk("first_fetch_stall", {31'b0, proc_stall}, 32'd1);
    chk("first_fetch_rdata", proc_rdata, 32'h0);

    // Cold miss: ready on the 3rd mem_read cycle -> 3 + 2 stall cycles
    fetch_miss(32'h40, d1, 3, st, ma);
    chk("cold_stalls", st, 32'd5);
    chk("cold_mem_addr", {4'b0, ma}, 32'h0000004);
    chk("cold_rdata", proc_rdata, 32'h20080005);
    chk("cold_stall0", {31'b0, proc_stall}, 32'd0);
    chk("cold_miss_cnt", {16'b0, miss_cnt}, 32'd1);

    // Back-to-back hits on the rest of the line; stray mem_ready ignored
    step; proc_addr = 32'h44; #1;
    chk("hit44_rdata", proc_rdata, 32'h0A0A0001);
    chk("hit44_stall", {31'b0, proc_stall}, 32'd0);
    step; proc_addr = 32'h48; mem_ready = 1'b1; #1;
    chk("hit48_rdata", proc_rdata, 32'h0B0B0002);
    chk("hit48_stall", {31'b0, proc_stall}, 32'd0);
    step; mem_ready = 1'b0; proc_addr = 32'h4C; #1;
    chk("hit4C_rdata", proc_rdata, 32'h0C0DE003);
    chk("hit4C_stall", {31'b0, proc_stall}, 32'd0);
    chk("hit4C_mem_read", {31'b0, mem_read}, 32'd0);
    chk("hits_miss_cnt", {16'b0, miss_cnt}, 32'd1);

    // Conflict on index 4
    step;
    fetch_miss(32'hC0, d2, 1, st, ma);
    chk("conf_stalls", st, 32'd3);
    chk("conf_mem_addr", {4'b0, ma}, 32'h000000C);
    chk("conf_rdata", proc_rdata, 32'hC0C0C0C0);
    step;
    fetch_miss(32'h40, d1, 1, st, ma);
    chk("refetch_stalls", st, 32'd3);
    chk("refetch_rdata", proc_rdata, 32'h20080005);
    chk("conf_miss_cnt", {16'b0, miss_cnt}, 32'd3);

    // proc_addr moves during MISS/FILL; the fill uses the latched line
    step; proc_addr = 32'h100; #1;
    chk("latch_miss", {31'b0, proc_stall}, 32'd1);
    step; proc_addr = 32'h200; #1;
    chk("latch_mem_read", {31'b0, mem_read}, 32'd1);
    chk("latch_mem_addr", {4'b0, mem_addr}, 32'h0000010);
    mem_ready = 1'b1; mem_rdata = d3;
    step; mem_ready = 1'b0; proc_addr = 32'h100; #1;
    chk("fill_mem_read", {31'b0, mem_read}, 32'd0);
    chk("fill_stall", {31'b0, proc_stall}, 32'd1);
    step; #1;
    chk("latch_hit_stall", {31'b0, proc_stall}, 32'd0);
    chk("latch_hit_rdata", proc_rdata, 32'h10010010);

    // Invalidate in IDLE
    step; proc_addr = 32'h44; inv = 1'b1; #1;
    chk("inv_cycle_hit", proc_rdata, 32'h0A0A0001);
    step; inv = 1'b0; #1;
    chk("inv_idle_miss", {31'b0, proc_stall}, 32'd1);
    chk("inv_idle_rdata", proc_rdata, 32'h0);
    fetch_miss(32'h44, d1, 1, st, ma);
    chk("inv_refill_stalls", st, 32'd3);
    chk("inv_refill_rdata", proc_rdata, 32'h0A0A0001);
    chk("inv_miss_cnt", {16'b0, miss_cnt}, 32'd5);

    // inv together with a miss still enters MISS; inv in MISS does not abort
    step; proc_addr = 32'h300; inv = 1'b1; #1;
    chk("inv_miss_stall", {31'b0, proc_stall}, 32'd1);
    step; #1;
    chk("inv_enter_miss", {31'b0, mem_read}, 32'd1);
    chk("inv_enter_addr", {4'b0, mem_addr}, 32'h0000030);
    step; inv = 1'b0; #1;
    chk("inv_no_abort", {31'b0, mem_read}, 32'd1);
    mem_ready = 1'b1; mem_rdata = d4;
    step; mem_ready = 1'b0;
    step; #1;
    chk("inv_miss_hit", proc_rdata, 32'h30030030);
    chk("inv_miss_cnt2", {16'b0, miss_cnt}, 32'd6);

    // inv during FILL leaves the line invalid and forces a second fill
    step; proc_addr = 32'h500; #1;
    step; mem_ready = 1'b1; mem_rdata = d5;
    step; mem_ready = 1'b0; inv = 1'b1; #1;
    chk("invf_fill_stall", {31'b0, proc_stall}, 32'd1);
    step; inv = 1'b0; #1;
    chk("invf_relookup_miss", {31'b0, proc_stall}, 32'd1);
    step; #1;
    chk("invf_second_fill", {31'b0, mem_read}, 32'd1);
    chk("invf_miss_cnt", {16'b0, miss_cnt}, 32'd8);
    mem_ready = 1'b1;
    step; mem_ready = 1'b0;
    step; #1;
    chk("invf_final_hit", proc_rdata, 32'h50050050);

    // Reset mid-fill
    step; proc_addr = 32'h600; #1;
    step; #1;
    chk("rmid_mem_read_pre", {31'b0, mem_read}, 32'd1);
    rst = 1'b0; #1;
    chk("rmid_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rmid_miss_cnt", {16'b0, miss_cnt}, 32'd0);
    step; rst = 1'b1; #1;
    chk("rmid_post_miss", {31'b0, proc_stall}, 32'd1);
    fetch_miss(32'h600, d6, 2, st, ma);
    chk("rmid_stalls", st, 32'd4);
    chk("rmid_rdata", proc_rdata, 32'h60060060);
    chk("rmid_miss_cnt2", {16'b0, miss_cnt}, 32'd1);

    // Saturation: preload the counter near the top, then keep missing
    step;
    force dut.miss_cnt = 16'hFFFD;
    #1;
    release dut.miss_cnt;
    fetch_miss(32'h700, d6, 1, st, ma);
    chk("sat_fffe", {16'b0, miss_cnt}, 32'h0000FFFE);
    step;
    fetch_miss(32'h800, d6, 1, st, ma);
    chk("sat_ffff", {16'b0, miss_cnt}, 32'h0000FFFF);
    step;
    fetch_miss(32'h900, d6, 1, st, ma);
    chk("sat_hold", {16'b0, miss_cnt}, 32'h0000FFFF);
    chk("sat_stalls", st, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter: IDX_W, default 3, index width (2**IDX_W direct-mapped lines, 4 words/line, tag = PC[31:IDX_W+4]).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: proc_addr  input  32  fetch PC from IF stage (byte address, bits[1:0] ignored).
REQ-005 SHALL have port: proc_rdata  output  32  instruction word returned to IF stage.
REQ-006 SHALL have port: proc_stall  output  1  high = IF stage holds PC/IF-ID registers.
REQ-007 SHALL have port: inv  input  1  invalidate all lines (one-cycle pulse).
REQ-008 SHALL have port: mem_read  output  1  line-fill request to memory.
REQ-009 SHALL have port: mem_addr  output  28  line address (PC[31:4]) of requested line.
REQ-010 SHALL have port: mem_rdata  input  128  fill data, word0 in bits[31:0], word3 in bits[127:96].
REQ-011 SHALL have port: mem_ready  input  1  memory data valid, qualifies mem_rdata for one cycle.
REQ-012 SHALL have port: miss_cnt  output  16  saturating miss counter.

Function
REQ-013 SHALL store per line: valid bit, tag, 128-bit data; index = proc_addr[IDX_W+3:4], word offset = proc_addr[3:2].
REQ-014 SHALL implement FSM states IDLE, MISS, FILL.
REQ-015 IDLE: hit = valid[idx] & tag match; hit -> proc_rdata = selected word, proc_stall = 0, same cycle (combinational, zero-latency).
REQ-016 IDLE miss -> proc_stall = 1 combinationally, proc_rdata = 32'h0 (NOP), latch proc_addr[31:4] into miss register, next state MISS.
REQ-017 MISS: mem_read = 1, mem_addr = latched line address, both stable until mem_ready sampled high; proc_stall = 1, proc_rdata = 0.
REQ-018 MISS & mem_ready: capture mem_rdata into line buffer, next state FILL; mem_read drops the following cycle.
REQ-019 FILL: write buffer data, tag, valid=1 into latched index; proc_stall = 1; next state IDLE, where re-lookup hits.
REQ-020 Miss penalty SHALL be (cycles until mem_ready) + 2; back-to-back hits SHALL sustain one instruction per cycle.
REQ-021 mem_ready outside MISS SHALL be ignored; mem_read SHALL be 0 in IDLE and FILL.
REQ-022 proc_addr changes during MISS/FILL SHALL not affect the fill (latched address used).
REQ-023 inv in any state SHALL clear all valid bits next edge; inv coincident with FILL SHALL leave the filled line invalid (inv priority); inv SHALL not abort an outstanding MISS handshake.
REQ-024 inv in IDLE with a miss the same cycle SHALL still enter MISS.
REQ-025 miss_cnt SHALL increment by 1 on each IDLE->MISS transition, saturating at 16'hFFFF (no wrap).
REQ-026 Fill into an index holding a valid different tag SHALL overwrite it (no write-back; read-only cache).

Reset
REQ-027 rst low SHALL asynchronously force: state IDLE, all valid bits 0, mem_read 0, mem_addr 0, miss_cnt 0, line buffer 0.
REQ-028 rst asserted during MISS/FILL SHALL abort the fill; the line SHALL remain invalid and mem_read SHALL drop immediately.
REQ-029 After reset release, first fetch SHALL miss (proc_stall = 1, proc_rdata = 0).

Verification
REQ-030 Cold miss: reset, proc_addr=0x00000040, mem_ready 3 cycles after mem_read with mem_rdata word0=0x20080005 -> mem_addr=0x0000004, stall for 5 cycles, then proc_rdata=0x20080005, stall 0, miss_cnt=1.
REQ-031 Line hits: after REQ-030 fill, proc_addr 0x44,0x48,0x4C on consecutive cycles -> words 1..3 returned, stall 0 each cycle, miss_cnt unchanged.
REQ-032 Conflict: fill 0x00000040 then fetch 0x000000C0 (same index, IDX_W=3) -> miss, line replaced; refetch 0x40 -> miss again, miss_cnt=3.
REQ-033 Invalidate: fill line, pulse inv in IDLE -> next fetch of same PC misses; inv during FILL -> following re-lookup misses, second fill requested.
REQ-034 Reset mid-fill: assert rst while in MISS with mem_read=1 -> mem_read=0 immediately; after release same PC misses, miss_cnt=1 after it.
REQ-035 Saturation: force 65537 misses -> miss_cnt holds 16'hFFFF.
